// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I-subset core: opcodes, ALU controls,
// immediate formats, PC sources and controller states.
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_e;
  typedef enum logic [1:0] {PC_PLUS4, PC_ALUOUT, PC_ALURES} pc_src_e;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_e;

endpackage

// File: rtl/mc_controller.sv
// Multicycle control FSM with main and ALU decoders; drives datapath enables
// and mux selects. Memory/trap/regfile strobes are forced low while in reset.
module mc_controller
  import riscv_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       ir_we_o,
  output logic       ab_we_o,
  output logic       data_we_o,
  output logic       aluout_we_o,
  output logic       aluout_src_o,
  output logic       rf_we_o,
  output logic       rf_wsrc_o,
  output logic       pc_we_o,
  output logic [1:0] pc_src_o,
  output logic       alu_srca_o,
  output logic       alu_srcb_o,
  output logic [1:0] imm_src_o,
  output logic [2:0] alu_ctrl_o,
  output logic       trap_o
);

  state_e     state_q, state_d;
  logic       r_ok, i_ok;
  logic [2:0] alu_dec;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    r_ok = ((funct7_i == 7'b0000000) && (funct3_i inside {3'b000, 3'b111, 3'b110, 3'b010}))
        || ((funct7_i == 7'b0100000) && (funct3_i == 3'b000));
    i_ok = funct3_i inside {3'b000, 3'b111, 3'b110, 3'b010};
    case (funct3_i)
      3'b111:  alu_dec = ALU_AND;
      3'b110:  alu_dec = ALU_OR;
      3'b010:  alu_dec = ALU_SLT;
      default: alu_dec = ((op_i == OP_R) && funct7_i[5]) ? ALU_SUB : ALU_ADD;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_we_o      = 1'b0;
    ab_we_o      = 1'b0;
    data_we_o    = 1'b0;
    aluout_we_o  = 1'b0;
    aluout_src_o = 1'b0;
    rf_we_o      = 1'b0;
    rf_wsrc_o    = 1'b0;
    pc_we_o      = 1'b0;
    pc_src_o     = PC_PLUS4;
    alu_srca_o   = 1'b0;
    alu_srcb_o   = 1'b0;
    imm_src_o    = IMM_I;
    alu_ctrl_o   = ALU_ADD;
    trap_o       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here so BEQ needs only a compare cycle.
        ab_we_o     = 1'b1;
        aluout_we_o = 1'b1;
        alu_srca_o  = 1'b1;
        alu_srcb_o  = 1'b1;
        imm_src_o   = IMM_B;
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = r_ok ? S_EXECR : S_TRAP;
          OP_I:         state_d = i_ok ? S_EXECI : S_TRAP;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        aluout_we_o = 1'b1;
        alu_srcb_o  = 1'b1;
        imm_src_o   = (op_i == OP_SW) ? IMM_S : IMM_I;
        state_d     = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
        if (mem_ready_i) begin
          data_we_o = 1'b1;
          state_d   = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we_o   = 1'b1;
        rf_wsrc_o = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        adr_src_o   = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        aluout_we_o = 1'b1;
        alu_srcb_o  = (state_q == S_EXECI);
        alu_ctrl_o  = alu_dec;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we_o = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        alu_ctrl_o = ALU_SUB;
        pc_we_o    = zero_i;
        pc_src_o   = PC_ALUOUT;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC already holds OldPC+4, which is the link value.
        pc_we_o      = 1'b1;
        pc_src_o     = PC_ALURES;
        alu_srca_o   = 1'b1;
        alu_srcb_o   = 1'b1;
        imm_src_o    = IMM_J;
        aluout_we_o  = 1'b1;
        aluout_src_o = 1'b1;
        state_d      = S_ALUWB;
      end
      S_TRAP:  trap_o = 1'b1;
      default: state_d = S_TRAP;
    endcase
    if (reset_i) begin
      mem_req_o   = 1'b0;
      mem_write_o = 1'b0;
      rf_we_o     = 1'b0;
      trap_o      = 1'b0;
    end
  end

endmodule

// File: rtl/riscv_multicycle.sv
// Multicycle RV32I-subset core with one shared, ready-handshaked memory port.
// Datapath is inline; sequencing lives in mc_controller.
module riscv_multicycle
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            MemReq,
  output logic            MemWrite,
  output logic [XLEN-1:0] MemAdr,
  output logic [XLEN-1:0] WriteData,
  input  logic [XLEN-1:0] ReadData,
  input  logic            MemReady,
  output logic            Trap
);

  logic [XLEN-1:0] pc_q, pc_d, oldpc_q, data_q, a_q, b_q, aluout_q;
  logic [31:0]     ir_q, imm32;
  logic [XLEN-1:0] imm, srca, srcb, alu_res, rs1_val, rs2_val, rf_wdata;
  logic [XLEN-1:0] rf_q [1:31];
  logic            adr_src, ir_we, ab_we, data_we, aluout_we, aluout_src;
  logic            rf_we, rf_wsrc, pc_we, alu_srca, alu_srcb;
  logic [1:0]      pc_src, imm_src;
  logic [2:0]      alu_ctrl;
  logic [4:0]      rd, rs1, rs2;

  mc_controller u_ctrl (
    .clk_i        (clk),
    .reset_i      (reset),
    .op_i         (ir_q[6:0]),
    .funct3_i     (ir_q[14:12]),
    .funct7_i     (ir_q[31:25]),
    .zero_i       (alu_res == '0),
    .mem_ready_i  (MemReady),
    .mem_req_o    (MemReq),
    .mem_write_o  (MemWrite),
    .adr_src_o    (adr_src),
    .ir_we_o      (ir_we),
    .ab_we_o      (ab_we),
    .data_we_o    (data_we),
    .aluout_we_o  (aluout_we),
    .aluout_src_o (aluout_src),
    .rf_we_o      (rf_we),
    .rf_wsrc_o    (rf_wsrc),
    .pc_we_o      (pc_we),
    .pc_src_o     (pc_src),
    .alu_srca_o   (alu_srca),
    .alu_srcb_o   (alu_srcb),
    .imm_src_o    (imm_src),
    .alu_ctrl_o   (alu_ctrl),
    .trap_o       (Trap)
  );

  assign rd  = ir_q[11:7];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];

  always_comb begin
    case (imm_src)
      IMM_S:   imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      IMM_B:   imm32 = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      IMM_J:   imm32 = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default: imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
    endcase
  end
  assign imm = XLEN'($signed(imm32));

  assign srca = alu_srca ? oldpc_q : a_q;
  assign srcb = alu_srcb ? imm : b_q;

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      ALU_SUB: alu_res = srca - srcb;
      ALU_AND: alu_res = srca & srcb;
      ALU_OR:  alu_res = srca | srcb;
      ALU_SLT: alu_res[0] = ($signed(srca) < $signed(srcb));
      default: alu_res = srca + srcb;
    endcase
  end

  always_comb begin
    case (pc_src)
      PC_ALUOUT: pc_d = aluout_q;
      PC_ALURES: pc_d = alu_res;
      default:   pc_d = pc_q + XLEN'(4);
    endcase
  end

  assign rs1_val   = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val   = (rs2 == 5'd0) ? '0 : rf_q[rs2];
  assign rf_wdata  = rf_wsrc ? data_q : aluout_q;
  assign MemAdr    = adr_src ? aluout_q : pc_q;
  assign WriteData = b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      oldpc_q  <= '0;
      ir_q     <= '0;
      data_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      if (pc_we) pc_q <= pc_d;
      if (ir_we) begin
        ir_q    <= ReadData[31:0];
        oldpc_q <= pc_q;
      end
      if (ab_we) begin
        a_q <= rs1_val;
        b_q <= rs2_val;
      end
      if (data_we)   data_q   <= ReadData;
      if (aluout_we) aluout_q <= aluout_src ? pc_q : alu_res;
    end
  end

  // Register file is deliberately not reset; x0 is never stored.
  always_ff @(posedge clk) begin
    if (rf_we && (rd != 5'd0)) rf_q[rd] <= rf_wdata;
  end

endmodule

// File: tb/tb_riscv_multicycle.sv
// Scoreboard bench for riscv_multicycle: expected memory transactions are queued
// by the stimulus and checked by a monitor as the core issues them.
module tb_riscv_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemReq, MemWrite, MemReady, Trap;
  logic [31:0] MemAdr, WriteData, ReadData;

  logic [31:0] mem [0:255];
  logic [31:0] stall_adr = 32'hFFFF_FFFC;
  int          stall_done;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    int          cyc;
  } exp_t;
  exp_t expq[$];

  riscv_multicycle #(.XLEN(32), .RESET_PC(32'h100)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemReq    (MemReq),
    .MemWrite  (MemWrite),
    .MemAdr    (MemAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .MemReady  (MemReady),
    .Trap      (Trap)
  );

  always #5 clk = ~clk;

  assign ReadData = mem[MemAdr[9:2]];
  assign MemReady = (MemAdr != stall_adr) || (stall_done >= 3);

  always @(posedge clk) begin
    if (reset) stall_done <= 0;
    else if (MemReq && (MemAdr == stall_adr) && (stall_done < 3)) stall_done <= stall_done + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every accepted request against the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) cyc = 0;
      else begin
        if (MemReq) begin
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_req: got adr %h we %b expected no request (cycle %0d)", MemAdr, MemWrite, cyc);
          end else begin
            e = expq[0];
            if (MemReady) begin
              void'(expq.pop_front());
              check("req_adr", MemAdr, e.adr);
              check("req_we", {31'd0, MemWrite}, {31'd0, e.we});
              if (e.we) check("store_data", WriteData, e.wd);
              check("req_cycle", cyc, e.cyc);
            end else begin
              check("stall_adr", MemAdr, e.adr);
              check("stall_we", {31'd0, MemWrite}, {31'd0, e.we});
            end
          end
        end
        cyc++;
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [2:0] f3,
                                        input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, 7'h13};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd, input logic [2:0] f3,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:0], rs1, 3'b010, rd, 7'h03};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic fe(input logic [31:0] adr, input int c);
    expq.push_back('{we: 1'b0, adr: adr, wd: 32'h0, cyc: c});
  endtask
  task automatic st(input logic [31:0] adr, input logic [31:0] wd, input int c);
    expq.push_back('{we: 1'b1, adr: adr, wd: wd, cyc: c});
  endtask
  task automatic lw_exp(input logic [31:0] adr, input int c);
    expq.push_back('{we: 1'b0, adr: adr, wd: 32'h0, cyc: c});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0073;
  endtask

  task automatic enter_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_memreq", {31'd0, MemReq}, 32'd0);
    check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check("rst_trap", {31'd0, Trap}, 32'd0);
    @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic finish_prog(input string nm);
    int n = 0;
    int reqs = 0;
    while (expq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    #2;
    if (expq.size() != 0) begin
      $display("FAIL %s_drain: got %0d pending expected 0", nm, expq.size());
      expq.delete();
    end
    total++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (MemReq) reqs++;
    end
    check({nm, "_trap"}, {31'd0, Trap}, 32'd1);
    check({nm, "_no_req_after_trap"}, reqs, 32'd0);
  endtask

  task automatic load_a();
    clear_mem();
    mem[32'h100 >> 2] = enc_i(5'd1, 3'b000, 5'd0, 32'd5);
    mem[32'h104 >> 2] = enc_i(5'd2, 3'b000, 5'd0, 32'd7);
    mem[32'h108 >> 2] = enc_r(7'h00, 5'd3, 3'b000, 5'd1, 5'd2);
    mem[32'h10C >> 2] = enc_sw(5'd3, 5'd0, 32'h40);
  endtask

  task automatic exp_a();
    fe(32'h100, 0);
    fe(32'h104, 4);
    fe(32'h108, 8);
    fe(32'h10C, 12);
    st(32'h040, 32'd12, 15);
    fe(32'h110, 16);
  endtask

  initial begin
    // Program A: ALU ops then store; 0x110 is the illegal 0x73 opcode.
    load_a();
    enter_reset();
    exp_a();
    release_reset();
    finish_prog("prog_a");

    // Reset out of the trap: must clear Trap and refetch from RESET_PC.
    enter_reset();
    exp_a();
    release_reset();
    finish_prog("prog_a_again");

    // Program B: load with three wait states, then store the loaded value.
    enter_reset();
    clear_mem();
    mem[32'h100 >> 2] = enc_lw(5'd4, 5'd0, 32'h80);
    mem[32'h104 >> 2] = enc_sw(5'd4, 5'd0, 32'h44);
    mem[32'h080 >> 2] = 32'hDEAD_BEEF;
    stall_adr = 32'h80;
    fe(32'h100, 0);
    lw_exp(32'h080, 6);
    fe(32'h104, 8);
    st(32'h044, 32'hDEAD_BEEF, 11);
    fe(32'h108, 12);
    release_reset();
    finish_prog("prog_b");

    // Program C: branches, jumps, remaining ALU ops.
    enter_reset();
    stall_adr = 32'hFFFF_FFFC;
    clear_mem();
    mem[32'h100 >> 2] = enc_jal(5'd0, 32'hFFFF_FF00);
    mem[32'h000 >> 2] = enc_i(5'd1, 3'b000, 5'd0, 32'd3);
    mem[32'h004 >> 2] = enc_i(5'd2, 3'b000, 5'd0, 32'd0);
    mem[32'h008 >> 2] = enc_i(5'd2, 3'b000, 5'd2, 32'd3);
    mem[32'h00C >> 2] = enc_r(7'h00, 5'd6, 3'b110, 5'd1, 5'd2);
    mem[32'h010 >> 2] = enc_beq(5'd1, 5'd2, 32'hFFFF_FFF8);
    mem[32'h014 >> 2] = enc_jal(5'd0, 32'h1C);
    mem[32'h030 >> 2] = enc_jal(5'd1, 32'h20);
    mem[32'h050 >> 2] = enc_sw(5'd1, 5'd0, 32'h200);
    mem[32'h054 >> 2] = enc_sw(5'd0, 5'd0, 32'h204);
    mem[32'h058 >> 2] = enc_sw(5'd6, 5'd0, 32'h208);
    mem[32'h05C >> 2] = enc_r(7'h20, 5'd7, 3'b000, 5'd0, 5'd1);
    mem[32'h060 >> 2] = enc_r(7'h00, 5'd8, 3'b010, 5'd7, 5'd1);
    mem[32'h064 >> 2] = enc_i(5'd9, 3'b111, 5'd7, 32'h0F0);
    mem[32'h068 >> 2] = enc_i(5'd10, 3'b010, 5'd1, 32'hFFFF_FFFF);
    mem[32'h06C >> 2] = enc_sw(5'd7, 5'd0, 32'h20C);
    mem[32'h070 >> 2] = enc_sw(5'd8, 5'd0, 32'h210);
    mem[32'h074 >> 2] = enc_sw(5'd9, 5'd0, 32'h214);
    mem[32'h078 >> 2] = enc_sw(5'd10, 5'd0, 32'h218);
    fe(32'h100, 0);
    fe(32'h000, 4);
    fe(32'h004, 8);
    fe(32'h008, 12);
    fe(32'h00C, 16);
    fe(32'h010, 20);
    fe(32'h008, 23);
    fe(32'h00C, 27);
    fe(32'h010, 31);
    fe(32'h014, 34);
    fe(32'h030, 38);
    fe(32'h050, 42);
    st(32'h200, 32'h34, 45);
    fe(32'h054, 46);
    st(32'h204, 32'h0, 49);
    fe(32'h058, 50);
    st(32'h208, 32'd7, 53);
    fe(32'h05C, 54);
    fe(32'h060, 58);
    fe(32'h064, 62);
    fe(32'h068, 66);
    fe(32'h06C, 70);
    st(32'h20C, 32'hFFFF_FFCC, 73);
    fe(32'h070, 74);
    st(32'h210, 32'd1, 77);
    fe(32'h074, 78);
    st(32'h214, 32'hC0, 81);
    fe(32'h078, 82);
    st(32'h218, 32'd0, 85);
    fe(32'h07C, 86);
    release_reset();
    finish_prog("prog_c");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
